// File: rtl/axi_amo_master.sv
`default_nettype none
// =============================================================================
// axi_amo_master : single-outstanding RISC-V LOAD/STORE/LR/SC/AMO to AXI4+ATOP
// initiator. Optional macro: AXI_AMO_MASTER_ALIGN_CHECK_EN.     Revision: 1.0
// =============================================================================
module axi_amo_master #(
  parameter int unsigned AXI_ADDR_WIDTH   = 64,
  parameter int unsigned AXI_DATA_WIDTH   = 64,
  parameter int unsigned RISCV_WORD_WIDTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [3:0]                    req_op_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [1:0]                    req_size_i,
  input  logic [RISCV_WORD_WIDTH-1:0]   req_wdata_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [RISCV_WORD_WIDTH-1:0]   rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          mst_aw_valid_o,
  input  logic                          mst_aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]     mst_aw_addr_o,
  output logic [2:0]                    mst_aw_size_o,
  output logic [5:0]                    mst_aw_atop_o,
  output logic                          mst_aw_lock_o,
  output logic                          mst_w_valid_o,
  input  logic                          mst_w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]     mst_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   mst_w_strb_o,
  input  logic                          mst_b_valid_i,
  output logic                          mst_b_ready_o,
  input  logic [1:0]                    mst_b_resp_i,
  output logic                          mst_ar_valid_o,
  input  logic                          mst_ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]     mst_ar_addr_o,
  output logic [2:0]                    mst_ar_size_o,
  output logic                          mst_ar_lock_o,
  input  logic                          mst_r_valid_i,
  output logic                          mst_r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]     mst_r_data_i,
  input  logic [1:0]                    mst_r_resp_i
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_WIDTH  = $clog2(STRB_WIDTH);
  localparam int unsigned RW         = RISCV_WORD_WIDTH;

  localparam logic [3:0] OP_LOAD = 4'd0, OP_STORE = 4'd1, OP_LR  = 4'd2, OP_SC  = 4'd3;
  localparam logic [3:0] OP_SWAP = 4'd4, OP_ADD   = 4'd5, OP_XOR = 4'd6, OP_AND = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8, OP_MIN   = 4'd9, OP_MAX = 4'd10;
  localparam logic [3:0] OP_MINU = 4'd11, OP_MAXU = 4'd12;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                op_q, op_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]                size_q, size_d;
  logic [OFF_WIDTH-1:0]      off_q, off_d;
  logic [5:0]                atop_q, atop_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     strb_q, strb_d;
  logic                      aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, ar_pend_q, ar_pend_d;
  logic                      r_exp_q, r_exp_d, b_exp_q, b_exp_d;
  logic [RW-1:0]             rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic                      legal, is_read;
  logic [5:0]                atop;
  logic [OFF_WIDTH-1:0]      size_mask, off;
  logic [RW-1:0]             operand;
  logic [AXI_DATA_WIDTH-1:0] op_wide, r_shift;
  logic [STRB_WIDTH-1:0]     strb_base;
  logic [RW-1:0]             r_word;
  logic                      unused_ok;

  // Request decode and lane placement, evaluated on the incoming request.
  always_comb begin
    legal   = 1'b1;
    atop    = 6'h00;
    is_read = (req_op_i == OP_LOAD) || (req_op_i == OP_LR);
    case (req_op_i)
      OP_LOAD, OP_STORE, OP_LR, OP_SC: atop = 6'h00;
      OP_SWAP: atop = 6'h30;
      OP_ADD:  atop = 6'h20;
      OP_AND:  atop = 6'h21;
      OP_XOR:  atop = 6'h22;
      OP_OR:   atop = 6'h23;
      OP_MAX:  atop = 6'h24;
      OP_MIN:  atop = 6'h25;
      OP_MAXU: atop = 6'h26;
      OP_MINU: atop = 6'h27;
      default: legal = 1'b0;
    endcase
    if (!((req_size_i == 2'd2) || ((req_size_i == 2'd3) && (RW == 64)))) legal = 1'b0;
    size_mask = OFF_WIDTH'((32'd1 << req_size_i) - 32'd1);
    off       = req_addr_i[OFF_WIDTH-1:0] & ~size_mask;
`ifdef AXI_AMO_MASTER_ALIGN_CHECK_EN
    if (|(req_addr_i[OFF_WIDTH-1:0] & size_mask)) legal = 1'b0;
`endif
    // AND is issued as an atomic clear, so the operand goes out inverted.
    operand = (req_op_i == OP_AND) ? ~req_wdata_i : req_wdata_i;
    if (req_size_i == 2'd2) operand = RW'(operand[31:0]);
    op_wide = '0;
    op_wide[RW-1:0] = operand;
    strb_base = '0;
    for (int i = 0; i < int'(STRB_WIDTH); i++) strb_base[i] = (i < (1 << req_size_i));
  end

  always_comb begin
    r_shift = mst_r_data_i >> {off_q, 3'b000};
    r_word  = (size_q == 2'd2) ? RW'($signed(r_shift[31:0])) : r_shift[RW-1:0];
  end

  assign unused_ok = ^{mst_r_resp_i[0], r_shift};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      off_q     <= '0;
      atop_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ar_pend_q <= 1'b0;
      r_exp_q   <= 1'b0;
      b_exp_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      off_q     <= off_d;
      atop_q    <= atop_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      ar_pend_q <= ar_pend_d;
      r_exp_q   <= r_exp_d;
      b_exp_q   <= b_exp_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    size_d    = size_q;
    off_d     = off_q;
    atop_d    = atop_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    ar_pend_d = ar_pend_q;
    r_exp_d   = r_exp_q;
    b_exp_d   = b_exp_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          off_d   = off;
          atop_d  = atop;
          wdata_d = op_wide << {off, 3'b000};
          strb_d  = strb_base << off;
          rdata_d = '0;
          err_d   = ~legal;
          if (legal) begin
            state_d   = BUSY;
            ar_pend_d = is_read;
            aw_pend_d = ~is_read;
            w_pend_d  = ~is_read;
            r_exp_d   = is_read || (atop != 6'h00);
            b_exp_d   = ~is_read;
          end else begin
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        if (mst_aw_ready_i) aw_pend_d = 1'b0;
        if (mst_w_ready_i)  w_pend_d  = 1'b0;
        if (mst_ar_ready_i) ar_pend_d = 1'b0;
        if (r_exp_q && mst_r_valid_i) begin
          r_exp_d = 1'b0;
          rdata_d = r_word;
          err_d   = err_d | mst_r_resp_i[1];
        end
        if (b_exp_q && mst_b_valid_i) begin
          b_exp_d = 1'b0;
          if (op_q == OP_SC) rdata_d = (mst_b_resp_i == 2'b01) ? '0 : RW'(1);
          err_d = err_d | mst_b_resp_i[1];
        end
        if (!(aw_pend_d || w_pend_d || ar_pend_d || r_exp_d || b_exp_d)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o    = (state_q == IDLE);
  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_rdata_o    = rdata_q;
  assign rsp_err_o      = err_q;
  assign mst_aw_valid_o = aw_pend_q;
  assign mst_aw_addr_o  = addr_q;
  assign mst_aw_size_o  = {1'b0, size_q};
  assign mst_aw_atop_o  = atop_q;
  assign mst_aw_lock_o  = (op_q == OP_SC);
  assign mst_w_valid_o  = w_pend_q;
  assign mst_w_data_o   = wdata_q;
  assign mst_w_strb_o   = strb_q;
  assign mst_b_ready_o  = b_exp_q;
  assign mst_ar_valid_o = ar_pend_q;
  assign mst_ar_addr_o  = addr_q;
  assign mst_ar_size_o  = {1'b0, size_q};
  assign mst_ar_lock_o  = (op_q == OP_LR);
  assign mst_r_ready_o  = r_exp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_amo_master.sv
`default_nettype none
// =============================================================================
// tb_axi_amo_master : directed self-checking bench for axi_amo_master.
// Revision: 1.0
// =============================================================================
module tb_axi_amo_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;
  logic        aw_valid, aw_ready, aw_lock;
  logic [63:0] aw_addr;
  logic [2:0]  aw_size;
  logic [5:0]  aw_atop;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready, ar_lock;
  logic [63:0] ar_addr;
  logic [2:0]  ar_size;
  logic        r_valid, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  axi_amo_master #(
    .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .RISCV_WORD_WIDTH(64)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .mst_aw_valid_o(aw_valid), .mst_aw_ready_i(aw_ready), .mst_aw_addr_o(aw_addr),
    .mst_aw_size_o(aw_size), .mst_aw_atop_o(aw_atop), .mst_aw_lock_o(aw_lock),
    .mst_w_valid_o(w_valid), .mst_w_ready_i(w_ready), .mst_w_data_o(w_data),
    .mst_w_strb_o(w_strb),
    .mst_b_valid_i(b_valid), .mst_b_ready_o(b_ready), .mst_b_resp_i(b_resp),
    .mst_ar_valid_o(ar_valid), .mst_ar_ready_i(ar_ready), .mst_ar_addr_o(ar_addr),
    .mst_ar_size_o(ar_size), .mst_ar_lock_o(ar_lock),
    .mst_r_valid_i(r_valid), .mst_r_ready_o(r_ready), .mst_r_data_i(r_data),
    .mst_r_resp_i(r_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; it is taken on the following posedge.
  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [1:0] sz,
                      input logic [63:0] d);
    req_valid = 1'b1; req_op = op; req_addr = a; req_size = sz; req_wdata = d;
    chk1("req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic slave(input logic rv, input logic [63:0] rd, input logic [1:0] rr,
                       input logic bv, input logic [1:0] br);
    r_valid = rv; r_data = rd; r_resp = rr; b_valid = bv; b_resp = br;
    @(negedge clk);
    r_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic take_rsp(input string tag, input logic [63:0] rd, input logic e);
    chk1({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, "_rdata"}, rsp_rdata, rd);
    chk1({tag, "_err"}, rsp_err, e);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk1({tag, "_rsp_done"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] wd;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_size = '0; req_wdata = '0;
    rsp_ready = 1'b0; aw_ready = 1'b1; w_ready = 1'b1; ar_ready = 1'b1;
    b_valid = 1'b0; b_resp = '0; r_valid = 1'b0; r_data = '0; r_resp = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 64'h0);
    chk1("rst_err", rsp_err, 1'b0);
    chk("rst_valids", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'h0);

    // ADD double, zero-wait slave; response three cycles after accept
    send(4'd5, 64'h1008, 2'd3, 64'd5);
    chk("add_valids", 64'({aw_valid, w_valid, ar_valid}), 64'b110);
    chk("add_atop", 64'(aw_atop), 64'h20);
    chk("add_size", 64'(aw_size), 64'd3);
    chk("add_addr", aw_addr, 64'h1008);
    chk("add_strb", 64'(w_strb), 64'hFF);
    chk("add_wdata", w_data, 64'd5);
    chk1("add_lock", aw_lock, 1'b0);
    @(negedge clk);
    chk("add_aw_w_done", 64'({aw_valid, w_valid}), 64'b00);
    chk("add_readies", 64'({r_ready, b_ready}), 64'b11);
    slave(1'b1, 64'h10, 2'b00, 1'b1, 2'b00);
    take_rsp("add", 64'h10, 1'b0);

    // AND word in the upper lane: inverted operand, sign-extended result
    send(4'd7, 64'h1004, 2'd2, 64'h0000FFFF);
    chk("and_atop", 64'(aw_atop), 64'h21);
    chk("and_strb", 64'(w_strb), 64'hF0);
    wd = w_data;
    chk("and_wdata_hi", 64'(wd[63:32]), 64'hFFFF0000);
    @(negedge clk);
    slave(1'b1, 64'h80000001_00000000, 2'b00, 1'b1, 2'b00);
    take_rsp("and", 64'hFFFFFFFF80000001, 1'b0);

    // LR then SC success / failure
    send(4'd2, 64'h2000, 2'd3, 64'd0);
    chk("lr_valids", 64'({aw_valid, w_valid, ar_valid}), 64'b001);
    chk1("lr_lock", ar_lock, 1'b1);
    chk("lr_addr", ar_addr, 64'h2000);
    chk("lr_size", 64'(ar_size), 64'd3);
    @(negedge clk);
    slave(1'b1, 64'd7, 2'b01, 1'b0, 2'b00);
    take_rsp("lr", 64'd7, 1'b0);
    send(4'd3, 64'h2000, 2'd3, 64'd9);
    chk1("sc_lock", aw_lock, 1'b1);
    chk("sc_atop", 64'(aw_atop), 64'h0);
    chk("sc_valids", 64'({aw_valid, w_valid, ar_valid}), 64'b110);
    @(negedge clk);
    chk1("sc_no_r_ready", r_ready, 1'b0);
    slave(1'b0, 64'd0, 2'b00, 1'b1, 2'b01);
    take_rsp("sc_ok", 64'd0, 1'b0);
    send(4'd3, 64'h2000, 2'd3, 64'd9);
    @(negedge clk);
    slave(1'b0, 64'd0, 2'b00, 1'b1, 2'b00);
    take_rsp("sc_fail", 64'd1, 1'b0);

    // SWAP with AW stalled five cycles; B ahead of R
    aw_ready = 1'b0;
    send(4'd4, 64'h3008, 2'd3, 64'hAA);
    chk("swap_valids", 64'({aw_valid, w_valid}), 64'b11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("swap_stall", 64'({aw_valid, w_valid, aw_atop}), 64'({1'b1, 1'b0, 6'h30}));
      chk("swap_stall_addr", aw_addr, 64'h3008);
    end
    aw_ready = 1'b1;
    @(negedge clk);
    chk1("swap_aw_done", aw_valid, 1'b0);
    slave(1'b0, 64'd0, 2'b00, 1'b1, 2'b00);
    chk("swap_after_b", 64'({rsp_valid, r_ready, b_ready}), 64'b010);
    slave(1'b1, 64'h55, 2'b00, 1'b0, 2'b00);
    take_rsp("swap", 64'h55, 1'b0);
    send(4'd4, 64'h3008, 2'd3, 64'hBB);
    @(negedge clk);
    slave(1'b1, 64'h66, 2'b00, 1'b1, 2'b00);
    take_rsp("swap2", 64'h66, 1'b0);
    @(negedge clk);
    chk1("swap2_single_rsp", rsp_valid, 1'b0);

    // Illegal op and size: error response, no bus traffic
    send(4'hF, 64'h100, 2'd3, 64'd1);
    chk("ill_op_valids", 64'({aw_valid, w_valid, ar_valid}), 64'b000);
    take_rsp("ill_op", 64'd0, 1'b1);
    send(4'd0, 64'h100, 2'd1, 64'd0);
    chk("ill_size_valids", 64'({aw_valid, w_valid, ar_valid}), 64'b000);
    take_rsp("ill_size", 64'd0, 1'b1);

`ifndef AXI_AMO_MASTER_ALIGN_CHECK_EN
    // Misaligned word load: low address bits below size are dropped
    send(4'd0, 64'h1006, 2'd2, 64'd0);
    chk1("mis_ar_valid", ar_valid, 1'b1);
    @(negedge clk);
    slave(1'b1, 64'h12345678_9ABCDEF0, 2'b00, 1'b0, 2'b00);
    take_rsp("mis_load", 64'h12345678, 1'b0);
`endif

    // STORE with SLVERR
    send(4'd1, 64'h4000, 2'd3, 64'h1234);
    @(negedge clk);
    slave(1'b0, 64'd0, 2'b00, 1'b1, 2'b10);
    take_rsp("store_err", 64'd0, 1'b1);

    // Reset mid-transaction
    aw_ready = 1'b0; w_ready = 1'b0;
    send(4'd1, 64'h5000, 2'd3, 64'd1);
    chk1("mid_aw_valid", aw_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valids", 64'({aw_valid, w_valid, ar_valid, rsp_valid}), 64'b0000);
    rst = 1'b0;
    aw_ready = 1'b1; w_ready = 1'b1;
    @(negedge clk);
    chk1("mid_req_ready", req_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("mid_quiet", 64'({rsp_valid, aw_valid, w_valid}), 64'b000);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi_amo_master.md
Name: axi_amo_master

Overview:
AXI4+ATOP initiator that turns single RISC-V memory/atomic requests (LOAD, STORE, LR, SC, AMO*) into AXI bursts with the correct atop/lock encoding. It sits between a core-side request/response port and the slave port of axi_riscv_atomics.
- One transaction in flight at a time.
- Fixed AXI fields (id, len=0, burst=INCR, last=1, cache/prot/qos/region/user=0) are tied off by the integrating wrapper and are not ports of this block.

Parameters:
AXI_ADDR_WIDTH, 64, AXI address width
AXI_DATA_WIDTH, 64, AXI data width (32 or 64; must be >= RISCV_WORD_WIDTH)
RISCV_WORD_WIDTH, 64, core word width (32 or 64)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i / req_ready_o  in/out  1  request handshake
req_op_i  in  4  0 LOAD, 1 STORE, 2 LR, 3 SC, 4 SWAP, 5 ADD, 6 XOR, 7 AND, 8 OR, 9 MIN, 10 MAX, 11 MINU, 12 MAXU; others illegal
req_addr_i  in  AXI_ADDR_WIDTH  byte address
req_size_i  in  2  2=word, 3=double (only if RISCV_WORD_WIDTH=64); others illegal
req_wdata_i  in  RISCV_WORD_WIDTH  operand, right-aligned
rsp_valid_o / rsp_ready_i  out/in  1  response handshake
rsp_rdata_o  out  RISCV_WORD_WIDTH  result
rsp_err_o  out  1  bus error or illegal request
mst_aw_valid_o / mst_aw_ready_i  out/in  1  AW handshake
mst_aw_addr_o  out  AXI_ADDR_WIDTH  AW address
mst_aw_size_o  out  3  AW size
mst_aw_atop_o  out  6  AW atop
mst_aw_lock_o  out  1  AW exclusive
mst_w_valid_o / mst_w_ready_i  out/in  1  W handshake
mst_w_data_o  out  AXI_DATA_WIDTH  W data
mst_w_strb_o  out  AXI_DATA_WIDTH/8  W strobes
mst_b_valid_i / mst_b_ready_o  in/out  1  B handshake
mst_b_resp_i  in  2  B response
mst_ar_valid_o / mst_ar_ready_i  out/in  1  AR handshake
mst_ar_addr_o  out  AXI_ADDR_WIDTH  AR address
mst_ar_size_o  out  3  AR size
mst_ar_lock_o  out  1  AR exclusive
mst_r_valid_i / mst_r_ready_o  in/out  1  R handshake
mst_r_data_i  in  AXI_DATA_WIDTH  R data
mst_r_resp_i  in  2  R response

Behaviour:
- Reset:
  - rst_i sampled on clk_i; next state IDLE.
  - All mst valid/ready outputs = 0; rsp_valid_o = 0; rsp_rdata_o = 0; rsp_err_o = 0.
  - req_ready_o = 1 in the first cycle after rst_i deasserts.
  - Reset mid-transaction abandons it; no response is produced.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready_o = 1. On accept, register op/addr/size/wdata.
  - IDLE to BUSY on a legal request; IDLE to RESP on an illegal op or size (err = 1, rdata = 0, no bus traffic).
- BUSY, channel use:
  - LOAD/LR: assert ar_valid; expect R.
  - STORE/SC: assert aw_valid and w_valid in the same cycle; expect B.
  - AMO: assert aw_valid and w_valid in the same cycle; expect both R and B.
- BUSY, handshake rules:
  - Each valid drops independently after its own handshake.
  - Valid and payload are held stable until ready; no retraction.
  - b_ready and r_ready are high in BUSY while the corresponding response is expected and not yet received.
  - R and B may arrive in either order or in the same cycle.
  - BUSY to RESP in the cycle after the last required handshake.
- RESP: rsp_valid_o = 1 with stable data until rsp_ready_i; then IDLE. No bypass.
- Minimum latency: accept at T, mst valids at T+1, rsp_valid at T+3 with zero-wait slave.
- atop encoding:
  - 0 for LOAD/STORE/LR/SC.
  - SWAP 0x30; ADD 0x20; AND 0x21 (operand bitwise-inverted before lane placement); XOR 0x22; OR 0x23.
  - MAX 0x24; MIN 0x25; MAXU 0x26; MINU 0x27.
- lock = 1 only for LR (AR) and SC (AW). size = req_size. Address is passed unchanged.
- Lane placement:
  - off = addr[log2(AXI_DATA_WIDTH/8)-1:0] with bits below size cleared.
  - w_data = operand << 8*off; w_strb = (2^(2^size) - 1) << off.
- Result:
  - Extract 2^size bytes at off from R data; size 2 is sign-extended to RISCV_WORD_WIDTH.
  - SC: rdata = 0 if B resp is EXOKAY (2'b01), else 1.
  - STORE: rdata = 0.
- Error: rsp_err_o = 1 if any received resp has bit 1 set (SLVERR/DECERR); rdata is still computed.

Optional Feature:
AXI_AMO_MASTER_ALIGN_CHECK_EN
- Defined: addr not aligned to 2^size produces an error response (err = 1, rdata = 0) with no bus traffic.
- Undefined: low address bits below size are ignored for lane selection and the request is issued.

Test Plan:
- ADD, size 3, addr 0x1008, wdata 5 -> atop 0x20, size 3, strb 0xFF, w_data 5; R 0x10 OKAY, B OKAY -> rdata 0x10, err 0.
- AND, size 2, addr 0x1004, wdata 0x0000FFFF -> atop 0x21, strb 0xF0, w_data[63:32] 0xFFFF0000; R 0x80000001_00000000 -> rdata 0xFFFFFFFF80000001.
- LR size 3 -> ar_lock 1; R EXOKAY data 7 -> rdata 7. Then SC -> aw_lock 1, atop 0; B EXOKAY -> rdata 0. Repeat SC with B OKAY -> rdata 1.
- SWAP with aw_ready low 5 cycles, w_ready high -> W accepted once, aw payload stable. B before R, then R and B in the same cycle on a repeat -> exactly one response each.
- op 0xF -> err 1, no mst valid ever high. STORE with B SLVERR -> err 1, rdata 0.
- rst_i pulsed while aw_valid is high -> all valids 0 next cycle; req_ready_o 1 after release; no response emitted.
